// File: rtl/sdf_butterfly_stage_pkg.sv
// ---------------------------------------------------------------------------
// sdf_butterfly_stage_pkg
//   Shared defaults and field helpers for the radix-2 SDF butterfly stage.
//   - W_DEF / D_DEF : default component width and butterfly span
//   - CNT_W         : sample-counter width for the default span, log2(2*D)
//   - re_*/im_*     : bit positions of the real/imag fields inside a packed
//                     word whose components are w bits wide ({re, im})
// ---------------------------------------------------------------------------
package sdf_butterfly_stage_pkg;

    localparam int W_DEF = 12;
    localparam int D_DEF = 4;

    // Counter width for a frame of 2*d samples.
    function automatic int frame_cnt_w(input int d);
        return $clog2(2 * d);
    endfunction

    localparam int CNT_W = frame_cnt_w(D_DEF);

    // Packed word layout: real part in the upper half, imag in the lower.
    function automatic int re_msb(input int w);
        return 2 * w - 1;
    endfunction

    function automatic int re_lsb(input int w);
        return w;
    endfunction

    function automatic int im_msb(input int w);
        return w - 1;
    endfunction

endpackage : sdf_butterfly_stage_pkg

// File: rtl/sdf_butterfly_stage_delay_line.sv
// ---------------------------------------------------------------------------
// sdf_delay_line
//   Enable-gated shift register used as the SDF feedback memory. Each enabled
//   cycle shifts din in; dout is the word written DEPTH enabled cycles ago.
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high clear of every entry
//     en   - shift enable; contents are frozen while low
//     din  - word shifted in
//     dout - oldest word
// ---------------------------------------------------------------------------
module sdf_delay_line #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: every entry is cleared on reset; the stage reads these entries as
    // real data in the first phase after reset, so they must not be X.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (en) begin
            mem_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout = mem_q[DEPTH-1];

endmodule : sdf_delay_line

// File: rtl/sdf_butterfly_stage.sv
// ---------------------------------------------------------------------------
// sdf_butterfly_stage
//   Radix-2 single-path delay-feedback butterfly. Each sample is paired with
//   the one D samples earlier through a D-deep feedback delay line. Per 2D
//   sample frame: during phase 1 (second half) the sums are emitted and the
//   differences (earlier minus later) are stored; during the next frame's
//   phase 0 the stored differences are emitted while the new first-half
//   samples are loaded. Output is registered, one cycle after the input.
//   Ports:
//     clk       - clock, rising edge
//     rst       - synchronous active-high reset
//     in_valid  - qualifies in_data; the stage only advances when high
//     in_data   - {re[W-1:0], im[W-1:0]}, two's complement
//     out_valid - qualifies out_data
//     out_data  - {re[W:0], im[W:0]}, full precision
//   D must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module sdf_butterfly_stage
    import sdf_butterfly_stage_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int D = D_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [2*W-1:0] in_data,
    output logic           out_valid,
    output logic [2*W+1:0] out_data
);

    localparam int CW = frame_cnt_w(D);
    localparam int EW = W + 1;
    localparam int RE_MSB = re_msb(W);
    localparam int RE_LSB = re_lsb(W);
    localparam int IM_MSB = im_msb(W);
    localparam logic [CW-1:0] CNT_LAST      = CW'(2 * D - 1);
    localparam logic [CW-1:0] CNT_HALF_LAST = CW'(D - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic              out_valid_q, out_valid_d;
    logic [2*EW-1:0]   out_data_q, out_data_d;

    logic              phase;
    logic signed [EW-1:0] x_re, x_im;
    logic signed [EW-1:0] d_re, d_im;
    logic signed [EW-1:0] sum_re, sum_im;
    logic signed [EW-1:0] dif_re, dif_im;
    logic [2*EW-1:0]   dl_din, dl_dout;

    assign phase = cnt_q[CW-1];

    // Sign-extend the input components to the full-precision width.
    assign x_re = {in_data[RE_MSB], in_data[RE_MSB:RE_LSB]};
    assign x_im = {in_data[IM_MSB], in_data[IM_MSB:0]};

    assign d_re = dl_dout[2*EW-1:EW];
    assign d_im = dl_dout[EW-1:0];

    // In phase 1 dout is a raw sign-extended sample, so W+1 bits are exact.
    assign sum_re = d_re + x_re;
    assign sum_im = d_im + x_im;
    assign dif_re = d_re - x_re;
    assign dif_im = d_im - x_im;

    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        dl_din      = {x_re, x_im};

        if (in_valid) begin
            // 2D is a power of two, so natural overflow is the frame wrap.
            cnt_d = cnt_q + CW'(1);

            if (phase) begin
                out_valid_d = 1'b1;
                out_data_d  = {sum_re, sum_im};
                dl_din      = {dif_re, dif_im};
            end else begin
                // Stored differences only exist once a full frame has passed.
                out_valid_d = pending_q;
                out_data_d  = dl_dout;
            end

            if (cnt_q == CNT_LAST) begin
                pending_d = 1'b1;
            end else if (cnt_q == CNT_HALF_LAST) begin
                pending_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    sdf_delay_line #(
        .WIDTH (2 * EW),
        .DEPTH (D)
    ) u_feedback (
        .clk  (clk),
        .rst  (rst),
        .en   (in_valid),
        .din  (dl_din),
        .dout (dl_dout)
    );

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule : sdf_butterfly_stage

// File: tb/tb_sdf_butterfly_stage.sv
// ---------------------------------------------------------------------------
// tb_sdf_butterfly_stage
//   Directed self-checking bench for sdf_butterfly_stage (W=12, D=4).
//   A frame-level reference tracks the expected out_valid/out_data for every
//   accepted sample; hand-computed output lists pin down the directed cases.
// ---------------------------------------------------------------------------
module tb_sdf_butterfly_stage;

    localparam int W  = 12;
    localparam int D  = 4;
    localparam int DW = 2 * W + 2;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [2*W-1:0]  in_data;
    logic            out_valid;
    logic [DW-1:0]   out_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level reference state.
    int            m_k;
    logic          has_prev;
    int            cur_re [D];
    int            cur_im [D];
    int            dif_re [D];
    int            dif_im [D];
    logic [DW-1:0] exp_data;
    int            n_sent;

    logic [DW-1:0] capq [$];

    sdf_butterfly_stage #(.W(W), .D(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack(input int re, input int im);
        return {re[W:0], im[W:0]};
    endfunction

    task automatic model_reset();
        m_k      = 0;
        has_prev = 1'b0;
        exp_data = '0;
        for (int i = 0; i < D; i++) begin
            cur_re[i] = 0; cur_im[i] = 0; dif_re[i] = 0; dif_im[i] = 0;
        end
    endtask

    // Pulse rst for one cycle; optionally with in_valid high (must be dropped).
    task automatic do_reset(input logic with_valid);
        rst      = 1'b1;
        in_valid = with_valid;
        in_data  = {W'(5), W'(7)};
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        model_reset();
        capq.delete();
    endtask

    // Present one sample, check the registered result, then idle for gaps cycles.
    task automatic send(input int re, input int im, input int gaps);
        int            k;
        logic          ev;
        logic [DW-1:0] ed;
        k = m_k;
        if (k >= D) begin
            ev = 1'b1;
            ed = pack(cur_re[k-D] + re, cur_im[k-D] + im);
            dif_re[k-D] = cur_re[k-D] - re;
            dif_im[k-D] = cur_im[k-D] - im;
        end else begin
            ev = has_prev;
            ed = pack(dif_re[k], dif_im[k]);
            cur_re[k] = re;
            cur_im[k] = im;
        end
        if (k == 2 * D - 1) has_prev = 1'b1;
        m_k      = (k + 1) % (2 * D);
        exp_data = ed;

        in_valid = 1'b1;
        in_data  = {re[W-1:0], im[W-1:0]};
        @(posedge clk); #1;
        in_valid = 1'b0;
        check($sformatf("valid[%0d]", n_sent), out_valid, ev);
        check($sformatf("data[%0d]", n_sent), out_data, ed);
        if (out_valid) capq.push_back(out_data);
        n_sent++;
        for (int g = 0; g < gaps; g++) begin
            @(posedge clk); #1;
            check($sformatf("gap_valid[%0d]", n_sent), out_valid, 1'b0);
            check($sformatf("gap_hold[%0d]", n_sent), out_data, exp_data);
        end
    endtask

    task automatic basic_frame(input int gaps);
        for (int i = 1; i <= 8; i++) send(i, -1, gaps);
        for (int i = 9; i <= 12; i++) send(i, 0, gaps);
    endtask

    task automatic check_basic_list(input string name);
        check({name, "_count"}, capq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_out%0d", name, i),
                  (i < capq.size()) ? capq[i] : 'x,
                  (i < 4) ? pack(6 + 2 * i, -2) : pack(-4, 0));
        end
    endtask

    initial begin
        logic [31:0] r;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        n_sent   = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, '0);
        rst = 1'b0;

        // Reset-first-phase: four samples after reset give no output.
        for (int i = 0; i < D; i++) send(100 + i, -100, 0);

        // Basic frame, no stalls.
        do_reset(1'b0);
        basic_frame(0);
        check_basic_list("basic");

        // Extremes.
        do_reset(1'b0);
        for (int i = 0; i < 12; i++) begin
            if (i == 0)      send(2047, -2048, 0);
            else if (i == 4) send(2047, 2047, 0);
            else             send(0, 0, 0);
        end
        check("ext_count", capq.size(), 8);
        check("ext_first_sum", (capq.size() > 0) ? capq[0] : 'x, {13'h0FFE, 13'h1FFF});
        check("ext_first_dif", (capq.size() > 4) ? capq[4] : 'x, {13'h0000, 13'h1001});

        // Stalls: three idle cycles after every sample.
        do_reset(1'b0);
        basic_frame(3);
        check_basic_list("stall");

        // Reset mid-frame (with in_valid high on the reset cycle), then a fresh frame.
        do_reset(1'b0);
        for (int i = 1; i <= 6; i++) send(i, -1, 0);
        do_reset(1'b1);
        for (int i = 1; i <= 8; i++) send(i, -1, 0);
        check("midrst_count", capq.size(), 4);
        check("midrst_first", (capq.size() > 0) ? capq[0] : 'x, pack(6, -2));

        // Back-to-back random frames plus drain.
        do_reset(1'b0);
        r = $urandom(32'd2024);
        for (int i = 0; i < 3 * 2 * D + D; i++) begin
            r = $urandom;
            send($signed(r[11:0]), $signed(r[27:16]), 0);
        end
        check("b2b_count", capq.size(), 3 * 2 * D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sdf_butterfly_stage

// File: doc/sdf_butterfly_stage.md
Name: sdf_butterfly_stage

Overview:
- Radix-2 single-path delay-feedback (SDF) butterfly stage for the complex datapath.
- Consumes a stream of packed complex samples {re, im} and pairs each sample with the one D samples earlier, using an internal D-deep delay line.
- Emits the sums x[n-D]+x[n] for the second half of each 2D-sample frame, then emits the stored differences x[n-D]-x[n] during the first half of the following frame.
- Sits downstream of the complex-add input stage and feeds the twiddle/next FFT stage.

Parameters:
- W, 12, bit width of each signed real/imag component at the input.
- D, 4, butterfly span in samples; must be a power of two and at least 2. The frame length is 2D.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies in_data; the stage advances only on cycles where in_valid=1.
- in_data  input  2W  {re[W-1:0], im[W-1:0]}, two's complement.
- out_valid  output  1  qualifies out_data.
- out_data  output  2W+2  {re[W:0], im[W:0]}, two's complement, full precision.

Behaviour:
- Reset:
  - rst is sampled only at the clk edge and is synchronous, active-high.
  - On reset: sample counter cnt=0, pending=0, out_valid=0, out_data=0, all delay-line entries=0.
  - Reset asserted mid-frame discards all stored samples and differences. The first valid sample after reset is sample 0 of a new frame.
- Counter:
  - cnt is log2(2D) bits wide and increments by 1 (wrapping 2D-1 to 0) on each cycle with in_valid=1. It holds otherwise.
  - phase = cnt MSB: phase 0 covers cnt 0..D-1, phase 1 covers cnt D..2D-1.
- Delay line:
  - D entries, each 2W+2 bits wide.
  - Shifts by one entry only when in_valid=1; dout is the entry written D valid cycles earlier.
  - With in_valid=0, contents are frozen.
- Arithmetic (per component; inputs sign-extended to W+1 bits; exact, no saturation or rounding):
  - Phase 0: delay-line input = sign-extended x; output candidate = dout (the difference stored in the previous frame).
  - Phase 1: output candidate = dout + x_ext (the sum); delay-line input = dout - x_ext (the difference). Order is always earlier minus later.
- Output timing:
  - out_data and out_valid are registered, so latency is exactly one clk cycle from the accepted input cycle.
  - Valid cycle in phase 1: out_valid=1 and out_data = sum.
  - Valid cycle in phase 0: out_valid=pending and out_data = dout.
  - Cycle with in_valid=0: out_valid=0 and out_data holds its previous value.
- pending flag:
  - Set on the valid cycle with cnt=2D-1.
  - Cleared on the valid cycle with cnt=D-1, unless it is set again on that same cycle, which cannot occur.
  - The first phase 0 after reset therefore produces no output.
- Output order per frame: D sums (frame samples D..2D-1), then D differences (during the next frame's samples 0..D-1).
  - Draining the last frame's differences requires the upstream to supply D further valid samples, whose data are loaded as a new frame.
- Stalls: in_valid may drop on any cycle for any number of cycles, and results are identical to an unstalled stream.
- Simultaneous rst and in_valid: rst wins and the sample is dropped.

Decomposition:
- Shared package/include:
  - default W and D;
  - the component-extraction helpers or localparams for the field positions of re/im within the packed words;
  - CNT_W = log2(2D).
- Sub-module sdf_delay_line (parameters WIDTH, DEPTH; ports clk, rst, en, din, dout):
  - enable-gated, synchronously cleared shift register;
  - instantiated once for the feedback path.

Test Plan:
- Basic frame: D=4, no stalls. Feed re=1..8, im=-1, then re=9..12, im=0.
  - Outputs start one cycle after the 5th sample.
  - Sums: re 6, 8, 10, 12 with im -2.
  - Then differences: re -4 ×4 with im 0.
  - Total 8 valid outputs with no gaps.
- Extremes: x[0]=(re 2047, im -2048), x[4]=(re 2047, im 2047), others 0.
  - First sum: re 4094 (0x0FFE), im -1.
  - First difference: re 0, im -4095 (0x1001).
- Stalls: same stimulus as the basic frame with in_valid low for 3 cycles between every pair of samples.
  - Identical output sequence; out_valid pulses exactly once per accepted sample in the output windows.
  - out_data holds during gaps.
- Reset mid-frame: assert rst for 1 cycle after the 6th sample of the basic frame, then feed a fresh 8-sample frame re=1..8.
  - No differences from the aborted frame appear.
  - First output is the sum re=6, one cycle after the new 5th sample.
- Back-to-back frames: 3 consecutive frames of random 12-bit data (seeded), then 4 drain samples.
  - Every output matches a golden model: sums and differences per frame, in order, at 1-cycle latency.
- Reset-first-phase: after reset, 4 valid samples only.
  - out_valid remains 0 throughout, with no spurious output from the zeroed delay line.
